// File: rtl/dram_bus_arbiter_if.sv
// ============================================================================
//  Module   : dram_bus_arbiter_if
//  Purpose  : CPU, DMA and DRAM-controller signal bundle for dram_bus_arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface dram_bus_arbiter_if;
    logic        CPU_CS;
    logic        CPU_AS;
    logic        CPU_UDS;
    logic        CPU_LDS;
    logic        CPU_RW;
    logic [23:1] CPU_ADDR;
    logic        CPU_DTACK;

    logic        DMA_REQ;
    logic        DMA_WE;
    logic [1:0]  DMA_BE;
    logic [23:1] DMA_ADDR;
    logic        DMA_ACK;
    logic        DMA_ERR;
    logic        GRANT_DMA;

    logic        DRAM_CS;
    logic        DRAM_AS;
    logic        DRAM_UDS;
    logic        DRAM_LDS;
    logic        DRAM_RW;
    logic [23:1] DRAM_ADDR;
    logic        DRAM_DTACK;

    // Arbiter side
    modport slave (
        input  CPU_CS, CPU_AS, CPU_UDS, CPU_LDS, CPU_RW, CPU_ADDR,
        output CPU_DTACK,
        input  DMA_REQ, DMA_WE, DMA_BE, DMA_ADDR,
        output DMA_ACK, DMA_ERR, GRANT_DMA,
        output DRAM_CS, DRAM_AS, DRAM_UDS, DRAM_LDS, DRAM_RW, DRAM_ADDR,
        input  DRAM_DTACK
    );

    // CPU / DMA / controller side
    modport master (
        output CPU_CS, CPU_AS, CPU_UDS, CPU_LDS, CPU_RW, CPU_ADDR,
        input  CPU_DTACK,
        output DMA_REQ, DMA_WE, DMA_BE, DMA_ADDR,
        input  DMA_ACK, DMA_ERR, GRANT_DMA,
        input  DRAM_CS, DRAM_AS, DRAM_UDS, DRAM_LDS, DRAM_RW, DRAM_ADDR,
        output DRAM_DTACK
    );
endinterface

`default_nettype wire

// File: rtl/dram_bus_arbiter.sv
// ============================================================================
//  Module   : dram_bus_arbiter
//  Purpose  : Shares the DRAM controller port between the 68000 and a DMA master.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dram_bus_arbiter #(
    parameter int STARVE_LIMIT  = 4,
    parameter int DMA_BURST_MAX = 4,
    parameter int DMA_TIMEOUT   = 32
) (
    input wire                CLK,
    input wire                RST,
    dram_bus_arbiter_if.slave bus
);

    localparam int c_SW = $clog2(STARVE_LIMIT + 1);
    localparam int c_BW = $clog2(DMA_BURST_MAX + 1);
    localparam int c_WW = $clog2(DMA_TIMEOUT);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);
    localparam logic [c_BW-1:0] c_BURST_MAX  = c_BW'(DMA_BURST_MAX);
    localparam logic [c_WW-1:0] c_WD_LAST    = c_WW'(DMA_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CPU_CYC = 2'd1,
        S_DMA_CYC = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t          r_state;
    logic [c_SW-1:0] r_starve_cnt;
    logic [c_BW-1:0] r_burst_cnt;
    logic [c_WW-1:0] r_wd_cnt;
    logic            r_dram_cs;
    logic            r_dram_as;
    logic            r_dram_uds;
    logic            r_dram_lds;
    logic            r_dram_rw;
    logic [23:1]     r_dram_addr;
    logic            r_dma_ack;
    logic            r_dma_err;
    logic            r_grant_dma;

    logic w_cpu_req;
    logic w_dma_req;
    logic w_pick_dma;
    logic w_cpu_phase;

    assign w_cpu_req   = ~bus.CPU_CS & ~bus.CPU_AS;
    assign w_dma_req   = bus.DMA_REQ;
    assign w_cpu_phase = (r_state == S_CPU_CYC);

    // A saturated burst counter overrides the starvation guard so the CPU gets back in.
    always_comb begin
        w_pick_dma = w_dma_req;
        if (w_cpu_req && w_dma_req)
            w_pick_dma = (r_burst_cnt != c_BURST_MAX) && (r_starve_cnt == c_STARVE_MAX);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
            r_burst_cnt  <= '0;
            r_wd_cnt     <= '0;
            r_dram_cs    <= 1'b1;
            r_dram_as    <= 1'b1;
            r_dram_uds   <= 1'b1;
            r_dram_lds   <= 1'b1;
            r_dram_rw    <= 1'b1;
            r_dram_addr  <= '0;
            r_dma_ack    <= 1'b0;
            r_dma_err    <= 1'b0;
            r_grant_dma  <= 1'b0;
        end else begin
            r_dma_ack <= 1'b0;
            r_dma_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cpu_req || w_dma_req) begin
                        if (w_pick_dma) begin
                            r_state      <= S_DMA_CYC;
                            r_grant_dma  <= 1'b1;
                            r_wd_cnt     <= '0;
                            r_dram_cs    <= 1'b0;
                            r_dram_as    <= 1'b0;
                            r_dram_rw    <= ~bus.DMA_WE;
                            r_dram_uds   <= ~bus.DMA_BE[1];
                            r_dram_lds   <= ~bus.DMA_BE[0];
                            r_dram_addr  <= bus.DMA_ADDR;
                            r_starve_cnt <= '0;
                            if (w_cpu_req && (r_burst_cnt != c_BURST_MAX))
                                r_burst_cnt <= r_burst_cnt + c_BW'(1);
                        end else begin
                            r_state     <= S_CPU_CYC;
                            r_burst_cnt <= '0;
                            if (w_dma_req && (r_starve_cnt != c_STARVE_MAX))
                                r_starve_cnt <= r_starve_cnt + c_SW'(1);
                        end
                    end
                end
                S_CPU_CYC: begin
                    if (bus.CPU_AS)
                        r_state <= S_RELEASE;
                end
                S_DMA_CYC: begin
                    if (!bus.DRAM_DTACK || (r_wd_cnt == c_WD_LAST)) begin
                        r_state    <= S_RELEASE;
                        r_dram_cs  <= 1'b1;
                        r_dram_as  <= 1'b1;
                        r_dram_uds <= 1'b1;
                        r_dram_lds <= 1'b1;
                        r_dram_rw  <= 1'b1;
                        r_dma_ack  <= ~bus.DRAM_DTACK;
                        r_dma_err  <= bus.DRAM_DTACK;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + c_WW'(1);
                    end
                end
                S_RELEASE: begin
                    // Controller is back in its idle state once it lets DTACK go.
                    if (bus.DRAM_DTACK) begin
                        r_state     <= S_IDLE;
                        r_grant_dma <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.DRAM_CS   = w_cpu_phase ? bus.CPU_CS     : r_dram_cs;
    assign bus.DRAM_AS   = w_cpu_phase ? bus.CPU_AS     : r_dram_as;
    assign bus.DRAM_UDS  = w_cpu_phase ? bus.CPU_UDS    : r_dram_uds;
    assign bus.DRAM_LDS  = w_cpu_phase ? bus.CPU_LDS    : r_dram_lds;
    assign bus.DRAM_RW   = w_cpu_phase ? bus.CPU_RW     : r_dram_rw;
    assign bus.DRAM_ADDR = w_cpu_phase ? bus.CPU_ADDR   : r_dram_addr;
    assign bus.CPU_DTACK = w_cpu_phase ? bus.DRAM_DTACK : 1'b1;
    assign bus.DMA_ACK   = r_dma_ack;
    assign bus.DMA_ERR   = r_dma_err;
    assign bus.GRANT_DMA = r_grant_dma;

endmodule

`default_nettype wire

// File: tb/tb_dram_bus_arbiter.sv
// ============================================================================
//  Module   : tb_dram_bus_arbiter
//  Purpose  : Transaction-level self-checking bench for dram_bus_arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dram_bus_arbiter;

    localparam int STARVE_LIMIT  = 4;
    localparam int DMA_BURST_MAX = 4;
    localparam int DMA_TIMEOUT   = 32;

    logic CLK;
    logic RST;

    dram_bus_arbiter_if bus ();

    dram_bus_arbiter #(
        .STARVE_LIMIT  (STARVE_LIMIT),
        .DMA_BURST_MAX (DMA_BURST_MAX),
        .DMA_TIMEOUT   (DMA_TIMEOUT)
    ) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: who is waiting, with what, plus the fairness counters
    bit          cpu_pend = 0;
    bit          dma_pend = 0;
    logic [23:1] c_addr;
    logic        c_rw, c_uds, c_lds;
    logic [23:1] d_addr;
    logic        d_we;
    logic [1:0]  d_be;
    int          m_starve = 0;
    int          m_burst  = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_ctl"},
                  {bus.DRAM_CS, bus.DRAM_AS, bus.DRAM_UDS, bus.DRAM_LDS, bus.DRAM_RW,
                   bus.CPU_DTACK, bus.DMA_ACK, bus.DMA_ERR, bus.GRANT_DMA},
                  9'b111111000);
        check_val({tag, "_addr"}, bus.DRAM_ADDR, 0);
    endtask

    task automatic new_cpu(input logic [23:1] a, input logic rw, input logic u, input logic l);
        c_addr = a; c_rw = rw; c_uds = u; c_lds = l;
        bus.CPU_ADDR = a; bus.CPU_RW = rw; bus.CPU_UDS = u; bus.CPU_LDS = l;
        bus.CPU_CS = 1'b0; bus.CPU_AS = 1'b0;
        cpu_pend = 1;
    endtask

    task automatic new_dma(input logic [23:1] a, input logic we, input logic [1:0] be);
        d_addr = a; d_we = we; d_be = be;
        bus.DMA_ADDR = a; bus.DMA_WE = we; bus.DMA_BE = be;
        bus.DMA_REQ = 1'b1;
        dma_pend = 1;
    endtask

    // One arbitration from IDLE through RELEASE back to IDLE
    task automatic run_round(input int dly, input bit stuck, input bit drop);
        bit exp_dma;
        bit early;
        if (!cpu_pend && !dma_pend) begin
            @(negedge CLK);
            check_val("idle_quiet", {bus.DRAM_AS, bus.CPU_DTACK, bus.GRANT_DMA}, 3'b110);
            return;
        end
        if (cpu_pend && dma_pend)
            exp_dma = (m_burst < DMA_BURST_MAX) && (m_starve >= STARVE_LIMIT);
        else
            exp_dma = dma_pend;
        if (exp_dma) begin
            m_starve = 0;
            if (cpu_pend && m_burst < DMA_BURST_MAX) m_burst++;
        end else begin
            m_burst = 0;
            if (dma_pend && m_starve < STARVE_LIMIT) m_starve++;
        end

        @(negedge CLK);
        check_val("grant", bus.GRANT_DMA, exp_dma);
        if (!exp_dma) begin
            check_val("cpu_ctl", {bus.DRAM_CS, bus.DRAM_AS, bus.DRAM_RW, bus.DRAM_UDS, bus.DRAM_LDS},
                      {2'b00, c_rw, c_uds, c_lds});
            check_val("cpu_addr", bus.DRAM_ADDR, c_addr);
            check_val("cpu_dtack_wait", bus.CPU_DTACK, 1);
            repeat (dly) @(negedge CLK);
            bus.DRAM_DTACK = 1'b0;
            #1;
            check_val("cpu_dtack_follow", bus.CPU_DTACK, 0);
            @(negedge CLK);
            bus.CPU_AS = 1'b1; bus.CPU_CS = 1'b1;
            cpu_pend = 0;
            @(negedge CLK);
            check_val("cpu_release", {bus.DRAM_CS, bus.DRAM_AS, bus.CPU_DTACK, bus.GRANT_DMA}, 4'b1110);
            if (dly % 2 == 1) begin
                @(negedge CLK);
                check_val("cpu_release_hold", {bus.DRAM_AS, bus.CPU_DTACK, bus.GRANT_DMA}, 3'b110);
            end
            bus.DRAM_DTACK = 1'b1;
            @(negedge CLK);
        end else begin
            check_val("dma_ctl", {bus.DRAM_CS, bus.DRAM_AS, bus.DRAM_RW, bus.DRAM_UDS, bus.DRAM_LDS},
                      {2'b00, ~d_we, ~d_be[1], ~d_be[0]});
            check_val("dma_addr", bus.DRAM_ADDR, d_addr);
            check_val("dma_cpu_wait", {bus.CPU_DTACK, bus.DMA_ACK, bus.DMA_ERR}, 3'b100);
            if (drop) bus.DMA_REQ = 1'b0;
            if (!stuck) begin
                repeat (dly) begin
                    @(negedge CLK);
                    check_val("dma_hold", {bus.DRAM_AS, bus.DMA_ACK}, 2'b00);
                end
                bus.DRAM_DTACK = 1'b0;
                @(negedge CLK);
                check_val("dma_ack", {bus.DMA_ACK, bus.DMA_ERR, bus.DRAM_CS, bus.DRAM_AS,
                                      bus.GRANT_DMA, bus.CPU_DTACK}, 6'b101111);
                bus.DMA_REQ = 1'b0;
                dma_pend = 0;
                bus.DRAM_DTACK = 1'b1;
                @(negedge CLK);
                check_val("dma_ack_done", {bus.DMA_ACK, bus.GRANT_DMA}, 2'b00);
            end else begin
                early = 0;
                for (int i = 1; i < DMA_TIMEOUT; i++) begin
                    @(negedge CLK);
                    if (bus.DMA_ERR || bus.DMA_ACK || bus.DRAM_AS) early = 1;
                end
                check_val("wd_hold", early, 0);
                @(negedge CLK);
                check_val("wd_err", {bus.DMA_ERR, bus.DMA_ACK, bus.DRAM_CS, bus.DRAM_AS,
                                     bus.GRANT_DMA}, 5'b10111);
                bus.DMA_REQ = 1'b0;
                dma_pend = 0;
                @(negedge CLK);
                check_val("wd_done", {bus.DMA_ERR, bus.GRANT_DMA}, 2'b00);
            end
        end
    endtask

    initial begin
        RST = 1'b0;
        bus.CPU_CS = 1'b1; bus.CPU_AS = 1'b1; bus.CPU_UDS = 1'b1; bus.CPU_LDS = 1'b1;
        bus.CPU_RW = 1'b1; bus.CPU_ADDR = '0;
        bus.DMA_REQ = 1'b0; bus.DMA_WE = 1'b0; bus.DMA_BE = 2'b00; bus.DMA_ADDR = '0;
        bus.DRAM_DTACK = 1'b1;
        repeat (3) @(negedge CLK);
        check_reset_vals("por");
        RST = 1'b1;
        @(negedge CLK);
        check_reset_vals("idle");

        // CPU read
        new_cpu(23'h000080, 1'b1, 1'b0, 1'b0);
        run_round(2, 0, 0);
        // DMA write, lower byte only
        new_dma(23'h400008, 1'b1, 2'b01);
        run_round(1, 0, 0);
        // Simultaneous request: CPU first, then DMA
        new_cpu(23'h001234, 1'b0, 1'b1, 1'b0);
        new_dma(23'h0ABCDE, 1'b0, 2'b11);
        run_round(0, 0, 0);
        run_round(3, 0, 0);
        // Starvation guard with DMA held across back-to-back CPU cycles
        new_dma(23'h200000, 1'b1, 2'b10);
        for (int i = 0; i < 5; i++) begin
            if (!cpu_pend) new_cpu(23'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            run_round(i % 3, 0, 0);
        end
        run_round(1, 0, 0);
        // BE=00 and a request dropped after grant
        new_dma(23'h000010, 1'b0, 2'b00);
        run_round(2, 0, 1);
        // Watchdog abort
        new_dma(23'h7FFFFE, 1'b1, 2'b11);
        run_round(0, 1, 0);

        for (int r = 0; r < 80; r++) begin
            if (!cpu_pend && $urandom_range(0, 1) == 1)
                new_cpu(23'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if (!dma_pend && $urandom_range(0, 2) != 0)
                new_dma(23'($urandom), 1'($urandom), 2'($urandom));
            run_round(int'($urandom_range(0, 4)), $urandom_range(0, 9) == 0,
                      $urandom_range(0, 4) == 0);
        end
        while (cpu_pend || dma_pend) run_round(1, 0, 0);

        // Reset in the middle of a DMA cycle with DTACK already low
        new_dma(23'h123456, 1'b1, 2'b11);
        @(negedge CLK);
        check_val("rst_dma_active", {bus.DRAM_AS, bus.GRANT_DMA}, 2'b01);
        RST = 1'b0;
        bus.DRAM_DTACK = 1'b0;
        @(negedge CLK);
        check_reset_vals("mid_rst");
        bus.DMA_REQ = 1'b0;
        dma_pend = 0;
        bus.DRAM_DTACK = 1'b1;
        m_starve = 0;
        m_burst  = 0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_reset_vals("post_rst");
        new_cpu(23'h000100, 1'b1, 1'b0, 1'b1);
        run_round(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
